// File: rtl/rns_conv_ctrl.sv
// Multi-cycle integer <-> RNS converter for moduli {256, 129}.
// Forward conversion folds bits MSB-first into a mod-129 remainder; reverse uses CRT with six modular doublings.
module rns_conv_ctrl #(
  parameter int DATA_W    = 16,
  parameter bit CHECK_RES = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_op,
  input  logic [DATA_W-1:0] req_din,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_dout,
  output logic              resp_err,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    B2R      = 3'd1,
    R2B_PREP = 3'd2,
    R2B_DBL  = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t            state_r, state_s;
  logic [3:0]        cnt_r, cnt_s;
  logic [DATA_W-1:0] din_r, din_s;
  logic [7:0]        acc_r, acc_s;
  logic [DATA_W-1:0] dout_s;
  logic              err_s;
  logic              valid_s;
  logic [8:0]        t_s;
  logic [7:0]        a_s;
  logic [8:0]        d_s;

  // Conditional subtract of 129 from a value known to be below 258.
  function automatic logic [7:0] red129(input logic [8:0] t);
    logic [8:0] s;
    s = t - 9'd129;
    if (t >= 9'd129) begin
      red129 = s[7:0];
    end else begin
      red129 = t[7:0];
    end
  endfunction

  // State register, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      cnt_r      <= 4'd0;
      din_r      <= '0;
      acc_r      <= 8'd0;
      resp_dout  <= '0;
      resp_err   <= 1'b0;
      resp_valid <= 1'b0;
      busy       <= 1'b0;
      req_ready  <= 1'b1;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      din_r      <= din_s;
      acc_r      <= acc_s;
      resp_dout  <= dout_s;
      resp_err   <= err_s;
      resp_valid <= valid_s;
      busy       <= (state_s != IDLE);
      req_ready  <= (state_s == IDLE);
    end
  end

  // Next-state and datapath; acc holds the mod-129 remainder (B2R) or the CRT digit k (R2B).
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    din_s   = din_r;
    acc_s   = acc_r;
    dout_s  = resp_dout;
    err_s   = resp_err;
    valid_s = resp_valid;
    t_s     = 9'd0;
    a_s     = 8'd0;
    d_s     = 9'd0;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          din_s = req_din;
          acc_s = 8'd0;
          if (!req_op) begin
            state_s = B2R;
            cnt_s   = 4'(DATA_W - 1);
          end else if (CHECK_RES && (req_din[7:0] > 8'd128)) begin
            state_s = DONE;
            dout_s  = '0;
            err_s   = 1'b1;
            valid_s = 1'b1;
          end else begin
            state_s = R2B_PREP;
          end
        end else begin
          state_s = IDLE;
        end
      end
      B2R: begin
        t_s   = {acc_r, 1'b0} + {8'd0, din_r[cnt_r]};
        acc_s = red129(t_s);
        cnt_s = cnt_r - 4'd1;
        if (cnt_r == 4'd0) begin
          state_s = DONE;
          dout_s  = {din_r[7:0], acc_s};
          err_s   = CHECK_RES && (din_r >= 16'd33024);
          valid_s = 1'b1;
        end else begin
          state_s = B2R;
        end
      end
      R2B_PREP: begin
        // d = (r129 - r256 mod 129) mod 129, then k = d * 64 mod 129 by doubling.
        a_s = red129({1'b0, din_r[15:8]});
        if (din_r[7:0] >= a_s) begin
          d_s = {1'b0, din_r[7:0]} - {1'b0, a_s};
        end else begin
          d_s = {1'b0, din_r[7:0]} + 9'd129 - {1'b0, a_s};
        end
        acc_s   = d_s[7:0];
        cnt_s   = 4'd5;
        state_s = R2B_DBL;
      end
      R2B_DBL: begin
        acc_s = red129({acc_r, 1'b0});
        cnt_s = cnt_r - 4'd1;
        if (cnt_r == 4'd0) begin
          state_s = DONE;
          dout_s  = {acc_s, din_r[15:8]};
          err_s   = 1'b0;
          valid_s = 1'b1;
        end else begin
          state_s = R2B_DBL;
        end
      end
      DONE: begin
        if (resp_ready) begin
          state_s = IDLE;
          valid_s = 1'b0;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
        valid_s = 1'b0;
      end
    endcase
  end

endmodule
